// File: rtl/top_keypad_scan.sv
// top_keypad_scan: 4x4 keypad scanner (clk, rst async high, ena, FEPU_BEPU_r read strobe, col_in active-low columns -> row_out one-hot-low rows, data_out last read of four key codes, key_valid sticky new-key flag); define KEYPAD_CLR_ON_READ_EN to clear the key history on read
module top_keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        FEPU_BEPU_r,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] data_out,
  output logic        key_valid
);
  localparam int PW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_TICKS < 2 ? 0 : DEBOUNCE_TICKS - 2);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] pre;
  logic [1:0] row_idx, row_nxt, col_idx;
  logic [DW-1:0] deb_cnt, deb_nxt, rel_cnt, rel_nxt;
  logic [3:0] code, code_nxt, cur;
  logic [15:0] data_reg;
  logic tick, press, rd, accept;
  assign tick    = ena && pre == PW'(SCAN_DIV - 1);
  assign press   = ~&col_in;
  assign col_idx = !col_in[0] ? 2'd0 : !col_in[1] ? 2'd1 : !col_in[2] ? 2'd2 : 2'd3;
  assign cur     = {row_idx, col_idx};
  assign rd      = ena & FEPU_BEPU_r;
  assign row_out = (ena && !rst) ? ~(4'b0001 << row_idx) : 4'b1111;
  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    deb_nxt   = deb_cnt;
    rel_nxt   = rel_cnt;
    code_nxt  = code;
    accept    = 1'b0;
    if (!ena) begin
      state_nxt = SCAN;
      row_nxt   = 2'd0;
      deb_nxt   = '0;
      rel_nxt   = '0;
    end else if (tick) begin
      case (state)
        SCAN: begin
          if (press) begin
            code_nxt  = cur;
            deb_nxt   = '0;
            state_nxt = DEBOUNCE;
          end else row_nxt = row_idx + 2'd1;
        end
        DEBOUNCE: begin
          if (press && cur == code) begin
            deb_nxt = deb_cnt + 1'b1;
            if (deb_cnt == LAST) begin
              accept    = 1'b1;
              rel_nxt   = '0;
              state_nxt = HOLD;
            end
          end else begin
            state_nxt = SCAN;
            row_nxt   = row_idx + 2'd1;
          end
        end
        HOLD: begin
          if (press) rel_nxt = '0;
          else if (rel_cnt == LAST) begin
            rel_nxt   = '0;
            state_nxt = SCAN;
            row_nxt   = row_idx + 2'd1;
          end else rel_nxt = rel_cnt + 1'b1;
        end
        default: state_nxt = SCAN;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      pre       <= '0;
      row_idx   <= 2'd0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      code      <= 4'h0;
      data_reg  <= 16'h0000;
      data_out  <= 16'h0000;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre       <= (!ena || tick) ? '0 : pre + 1'b1;
      row_idx   <= row_nxt;
      deb_cnt   <= deb_nxt;
      rel_cnt   <= rel_nxt;
      code      <= code_nxt;
`ifdef KEYPAD_CLR_ON_READ_EN
      data_reg  <= accept ? (rd ? {12'h000, code} : {data_reg[11:0], code}) : rd ? 16'h0000 : data_reg;
`else
      data_reg  <= accept ? {data_reg[11:0], code} : data_reg;
`endif
      data_out  <= rd ? data_reg : data_out;
      key_valid <= accept | (key_valid & ~rd);
    end
  end
endmodule

// File: tb/tb_top_keypad_scan.sv
// tb_top_keypad_scan: scoreboard bench for top_keypad_scan with a behavioural keypad (SCAN_DIV=4, DEBOUNCE_TICKS=3)
module tb_top_keypad_scan;
  logic clk, rst, ena, FEPU_BEPU_r;
  logic [3:0] col_in, row_out;
  logic [15:0] data_out;
  logic key_valid;
  logic key_down;
  logic [1:0] key_row, key_col;
  logic [15:0] model_reg, last_read;
  logic [15:0] exp_q[$];
  int tests, fails;
  top_keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .ena(ena), .FEPU_BEPU_r(FEPU_BEPU_r), .col_in(col_in),
    .row_out(row_out), .data_out(data_out), .key_valid(key_valid)
  );
  assign col_in = (key_down && !row_out[key_row]) ? ~(4'b0001 << key_col) : 4'hF;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic read_bus(input string tag);
    exp_q.push_back(model_reg);
`ifdef KEYPAD_CLR_ON_READ_EN
    model_reg = 16'h0000;
`endif
    FEPU_BEPU_r = 1'b1;
    cyc(1);
    FEPU_BEPU_r = 1'b0;
    last_read = exp_q.pop_front();
    chk(tag, data_out, last_read);
    chk({tag, "_kv"}, {15'd0, key_valid}, 16'd0);
  endtask
  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_row = r;
    key_col = c;
    key_down = 1'b1;
    cyc(60);
    key_down = 1'b0;
    cyc(40);
    model_reg = {model_reg[11:0], r, c};
  endtask
  initial begin
    int n;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    ena = 1'b1;
    FEPU_BEPU_r = 1'b0;
    key_down = 1'b0;
    key_row = 2'd0;
    key_col = 2'd0;
    model_reg = 16'h0000;
    last_read = 16'h0000;
    cyc(3);
    chk("rst_row", {12'd0, row_out}, 16'h000F);
    chk("rst_data", data_out, 16'h0000);
    chk("rst_kv", {15'd0, key_valid}, 16'd0);
    rst = 1'b0;
    #1;
    chk("row0", {12'd0, row_out}, 16'h000E);
    cyc(4);
    chk("row1", {12'd0, row_out}, 16'h000D);
    cyc(4);
    chk("row2", {12'd0, row_out}, 16'h000B);
    cyc(4);
    chk("row3", {12'd0, row_out}, 16'h0007);
    cyc(4);
    chk("row_wrap", {12'd0, row_out}, 16'h000E);
    key_row = 2'd1;
    key_col = 2'd2;
    key_down = 1'b1;
    n = 0;
    do begin cyc(1); n++; end while (!key_valid && n < 100);
    chk("single_kv", {15'd0, key_valid}, 16'd1);
    key_down = 1'b0;
    cyc(40);
    model_reg = {model_reg[11:0], 4'h6};
    read_bus("single_rd");
    key_row = 2'd2;
    key_col = 2'd0;
    n = 0;
    while (!row_out[2] && n < 20) begin cyc(1); n++; end
    while (row_out[2] && n < 40) begin cyc(1); n++; end
    key_down = 1'b1;
    cyc(4);
    key_down = 1'b0;
    chk("bounce_kv0", {15'd0, key_valid}, 16'd0);
    cyc(4);
    chk("bounce_row", {12'd0, row_out}, 16'h0007);
    chk("bounce_kv1", {15'd0, key_valid}, 16'd0);
    cyc(20);
    chk("bounce_kv2", {15'd0, key_valid}, 16'd0);
    press(2'd0, 2'd1);
    press(2'd0, 2'd2);
    press(2'd0, 2'd3);
    press(2'd1, 2'd0);
    chk("seq_kv", {15'd0, key_valid}, 16'd1);
    read_bus("seq_rd");
`ifdef KEYPAD_CLR_ON_READ_EN
    read_bus("clr_rd");
`else
    key_row = 2'd1;
    key_col = 2'd1;
    key_down = 1'b1;
    FEPU_BEPU_r = 1'b1;
    exp_q.push_back(model_reg);
    n = 0;
    do begin cyc(1); n++; end while (!key_valid && n < 100);
    chk("col_data", data_out, exp_q.pop_front());
    chk("col_kv", {15'd0, key_valid}, 16'd1);
    model_reg = {model_reg[11:0], 4'h5};
    exp_q.push_back(model_reg);
    cyc(1);
    FEPU_BEPU_r = 1'b0;
    last_read = exp_q.pop_front();
    chk("col_next", data_out, last_read);
    chk("col_next_kv", {15'd0, key_valid}, 16'd0);
    key_down = 1'b0;
    cyc(40);
`endif
    key_row = 2'd0;
    key_col = 2'd0;
    key_down = 1'b1;
    cyc(8);
    ena = 1'b0;
    cyc(1);
    chk("dis_row", {12'd0, row_out}, 16'h000F);
    chk("dis_kv", {15'd0, key_valid}, 16'd0);
    chk("dis_data", data_out, last_read);
    key_down = 1'b0;
    cyc(3);
    ena = 1'b1;
    #1;
    chk("ena_row0", {12'd0, row_out}, 16'h000E);
    cyc(40);
    chk("discard_kv", {15'd0, key_valid}, 16'd0);
    press(2'd0, 2'd1);
    chk("retain_kv0", {15'd0, key_valid}, 16'd1);
    ena = 1'b0;
    cyc(5);
    chk("retain_kv1", {15'd0, key_valid}, 16'd1);
    chk("retain_row", {12'd0, row_out}, 16'h000F);
    ena = 1'b1;
    read_bus("retain_rd");
    key_row = 2'd1;
    key_col = 2'd3;
    key_down = 1'b1;
    cyc(8);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_data", data_out, 16'h0000);
    chk("mid_rst_kv", {15'd0, key_valid}, 16'd0);
    chk("mid_rst_row", {12'd0, row_out}, 16'h000F);
    key_down = 1'b0;
    rst = 1'b0;
    model_reg = 16'h0000;
    cyc(40);
    chk("post_rst_kv", {15'd0, key_valid}, 16'd0);
    read_bus("post_rst_rd");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
